// File: rtl/keypad_input_pkg.sv
// Shared input-interface command codes plus keypad-local key map and FSM encodings.
package keypad_input_pkg;

  localparam int IC_N     = 5;
  localparam int NUM_KEYS = 20;

  localparam logic [IC_N-1:0] IC_NONE   = 5'd0;
  // Digit d is encoded as IC_DIGIT0 + d, so digit codes occupy 1..10.
  localparam logic [IC_N-1:0] IC_DIGIT0 = 5'd1;
  localparam logic [IC_N-1:0] IC_PLUS   = 5'd11;
  localparam logic [IC_N-1:0] IC_MINUS  = 5'd12;
  localparam logic [IC_N-1:0] IC_MUL    = 5'd13;
  localparam logic [IC_N-1:0] IC_DIV    = 5'd14;
  localparam logic [IC_N-1:0] IC_LPAR   = 5'd15;
  localparam logic [IC_N-1:0] IC_RPAR   = 5'd16;
  localparam logic [IC_N-1:0] IC_OK     = 5'd17;
  localparam logic [IC_N-1:0] IC_CLBK   = 5'd18;
  localparam logic [IC_N-1:0] IC_CLCL   = 5'd19;

  typedef enum logic [1:0] {
    KP_IDLE,
    KP_DEBOUNCE,
    KP_HELD,
    KP_RELEASE
  } kpState_e;

  function automatic logic [IC_N-1:0] keyToCmd(input logic [4:0] idx);
    case (idx)
      5'd10:   return IC_PLUS;
      5'd11:   return IC_MINUS;
      5'd12:   return IC_MUL;
      5'd13:   return IC_DIV;
      5'd14:   return IC_LPAR;
      5'd15:   return IC_RPAR;
      5'd16:   return IC_OK;
      5'd17:   return IC_CLBK;
      5'd18:   return IC_CLCL;
      default: return (idx < 5'd10) ? IC_DIGIT0 + idx : IC_NONE;
    endcase
  endfunction

  function automatic logic [4:0] firstSetIdx(input logic [NUM_KEYS-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_input_if.sv
// Command handshake between the keypad front end and its controller.
interface keypad_input_if;
  import keypad_input_pkg::*;

  logic [IC_N-1:0] in_cmd;
  logic            in_ack;
  logic            ovf;

  modport master (output in_cmd, output ovf, input in_ack);
  modport slave  (input in_cmd, input ovf, output in_ack);
endinterface

// File: rtl/keypad_input_cmd_fifo2.sv
// Two-entry command queue; the head register reads IC_NONE whenever the queue is empty.
module cmd_fifo2
  import keypad_input_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic            push_i,
  input  logic [IC_N-1:0] data_i,
  input  logic            pop_i,
  output logic [IC_N-1:0] head_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [IC_N-1:0] head_q, tail_q;
  logic [1:0]      count_q;
  logic            doPop, doPush;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign head_o  = head_q;

  // A push that lands on a pop slides into whichever slot the pop just freed.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      head_q  <= IC_NONE;
      tail_q  <= IC_NONE;
      count_q <= 2'd0;
    end else begin
      case ({doPush, doPop})
        2'b10: begin
          if (empty_o) head_q <= data_i;
          else         tail_q <= data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= full_o ? tail_q : IC_NONE;
          tail_q  <= IC_NONE;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (full_o) begin
            head_q <= tail_q;
            tail_q <= data_i;
          end else begin
            head_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_input.sv
// 5x4 matrix keypad scanner with per-pass debounce, key-to-command mapping and a 2-deep command queue.
module keypad_input
  import keypad_input_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEB_N    = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  output logic [4:0]     kp_row,
  input  logic [3:0]     kp_col,
  keypad_input_if.master cmdIf
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_N + 1);

  logic [3:0]      colMeta_q, colSync_q;
  logic [DW-1:0]   div_q;
  logic [2:0]      row_q;
  logic [4:0]      kpRow_q;
  logic [15:0]     snapAcc_q;
  kpState_e        state_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      keyIdx_q;
  logic            push_q;
  logic [IC_N-1:0] pushCode_q;
  logic            ovf_q;

  logic [3:0]          colPressed;
  logic                rowDone, passDone;
  logic [NUM_KEYS-1:0] snap, keyMask;
  logic                snapOne, snapNone;
  logic                fifoFull, fifoEmpty;
  logic [IC_N-1:0]     fifoHead;

  assign colPressed = ~colSync_q;
  assign rowDone    = (div_q == DW'(SCAN_DIV - 1));
  assign passDone   = rowDone && (row_q == 3'd4);
  // Row 4 is still being sampled on the pass edge, so it comes straight from the synchronizer; key 19 is masked off.
  assign snap       = {1'b0, colPressed[2:0], snapAcc_q};
  assign keyMask    = {{(NUM_KEYS-1){1'b0}}, 1'b1} << keyIdx_q;
  assign snapOne    = ($countones(snap) == 1);
  assign snapNone   = (snap == '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      colMeta_q <= 4'hF;
      colSync_q <= 4'hF;
    end else begin
      colMeta_q <= kp_col;
      colSync_q <= colMeta_q;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q     <= '0;
      row_q     <= 3'd0;
      kpRow_q   <= 5'b11110;
      snapAcc_q <= '0;
    end else if (rowDone) begin
      div_q <= '0;
      if (row_q == 3'd4) begin
        row_q   <= 3'd0;
        kpRow_q <= 5'b11110;
      end else begin
        row_q     <= row_q + 3'd1;
        kpRow_q   <= {kpRow_q[3:0], 1'b1};
        snapAcc_q[{row_q[1:0], 2'b00} +: 4] <= colPressed;
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // The FSM only moves once per completed pass; cnt_q counts matching passes in DEBOUNCE and RELEASE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= KP_IDLE;
      cnt_q      <= '0;
      keyIdx_q   <= '0;
      push_q     <= 1'b0;
      pushCode_q <= IC_NONE;
    end else begin
      push_q <= 1'b0;
      if (passDone) begin
        case (state_q)
          KP_IDLE: begin
            if (snapOne) begin
              state_q  <= KP_DEBOUNCE;
              keyIdx_q <= firstSetIdx(snap);
              cnt_q    <= CW'(1);
            end
          end
          KP_DEBOUNCE: begin
            if (snap == keyMask) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CW'(DEB_N - 1)) begin
                push_q     <= 1'b1;
                pushCode_q <= keyToCmd(keyIdx_q);
                state_q    <= KP_HELD;
              end
            end else begin
              state_q <= KP_IDLE;
              cnt_q   <= '0;
            end
          end
          KP_HELD: begin
            if (snapNone) begin
              state_q <= KP_RELEASE;
              cnt_q   <= CW'(1);
            end
          end
          KP_RELEASE: begin
            if (!snapNone) begin
              state_q <= KP_HELD;
            end else if (cnt_q == CW'(DEB_N - 1)) begin
              state_q <= KP_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= KP_IDLE;
        endcase
      end
    end
  end

  cmd_fifo2 uFifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push_i  (push_q),
    .data_i  (pushCode_q),
    .pop_i   (cmdIf.in_ack),
    .head_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) ovf_q <= 1'b0;
    else if (push_q && fifoFull && !(cmdIf.in_ack && !fifoEmpty)) ovf_q <= 1'b1;
  end

  assign kp_row       = kpRow_q;
  assign cmdIf.in_cmd = fifoHead;
  assign cmdIf.ovf    = ovf_q;

endmodule

// File: tb/tb_keypad_input.sv
// Keypad front end bench: a key-matrix model drives the DUT and a pass-level behavioural model predicts every output.
module tb_keypad_input;
  import keypad_input_pkg::*;

  localparam int SCAN_DIV = 16;
  localparam int DEB_N    = 4;
  localparam int PASS     = 5 * SCAN_DIV;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [4:0]  kp_row;
  logic [3:0]  kp_col;
  logic [19:0] keys = '0;

  keypad_input_if cmdIf ();

  keypad_input #(.SCAN_DIV(SCAN_DIV), .DEB_N(DEB_N)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .kp_row (kp_row),
    .kp_col (kp_col),
    .cmdIf  (cmdIf)
  );

  always #5 Clock = ~Clock;

  // A pressed key pulls its column low while its row is driven low.
  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (!kp_row[r] && keys[r*4 + c]) kp_col[c] = 1'b0;
  end

  int checkCnt = 0;
  int passCnt  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: keys are only changed at pass starts, so each pass sees exactly the current keys vector.
  int              edgeCnt = 0;
  logic [IC_N-1:0] mq[$];
  bit              mOvf = 1'b0;
  bit              pendHave = 1'b0;
  logic [IC_N-1:0] pendCode = IC_NONE;
  int              phase = 0;
  int              cand = 0;
  int              runLen = 0;
  logic [19:0]     snapM;
  int              nOn, onlyIdx;

  function automatic logic [IC_N-1:0] modelCode(input int idx);
    logic [IC_N-1:0] tbl [9] = '{IC_PLUS, IC_MINUS, IC_MUL, IC_DIV, IC_LPAR,
                                 IC_RPAR, IC_OK, IC_CLBK, IC_CLCL};
    if (idx < 10) return IC_DIGIT0 + IC_N'(idx);
    return tbl[idx - 10];
  endfunction

  function automatic logic [IC_N-1:0] modelHead();
    return (mq.size() > 0) ? mq[0] : IC_NONE;
  endfunction

  function automatic logic [4:0] expRow();
    logic [4:0] e;
    e = 5'h1F;
    e[(edgeCnt % PASS) / SCAN_DIV] = 1'b0;
    return e;
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      edgeCnt  = 0;
      mq.delete();
      mOvf     = 1'b0;
      pendHave = 1'b0;
      phase    = 0;
      runLen   = 0;
    end else begin
      edgeCnt++;
      if (cmdIf.in_ack && mq.size() > 0) void'(mq.pop_front());
      if (pendHave) begin
        if (mq.size() < 2) mq.push_back(pendCode);
        else mOvf = 1'b1;
        pendHave = 1'b0;
      end
      if (edgeCnt % PASS == 0) begin
        snapM   = keys & 20'h7FFFF;
        nOn     = $countones(snapM);
        onlyIdx = -1;
        for (int i = 0; i < 20; i++) if (snapM[i]) onlyIdx = i;
        case (phase)
          0: if (nOn == 1) begin cand = onlyIdx; runLen = 1; phase = 1; end
          1: begin
            if (nOn == 1 && onlyIdx == cand) begin
              runLen++;
              if (runLen == DEB_N) begin
                pendHave = 1'b1;
                pendCode = modelCode(cand);
                phase    = 2;
              end
            end else begin
              phase = 0;
            end
          end
          2: if (nOn == 0) begin phase = 3; runLen = 1; end
          default: begin
            if (nOn != 0) phase = 2;
            else begin
              runLen++;
              if (runLen == DEB_N) phase = 0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge Clock) begin
    checkOutput("in_cmd", cmdIf.in_cmd, modelHead());
    checkOutput("ovf", cmdIf.ovf, mOvf);
    checkOutput("kp_row", kp_row, expRow());
  end

  task automatic waitPasses(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge Clock); while (edgeCnt % PASS != 0);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] k, input int passes);
    if (edgeCnt % PASS != 0) waitPasses(1);
    keys = k;
    waitPasses(passes);
  endtask

  task automatic ackOnce();
    cmdIf.in_ack = 1'b1;
    @(negedge Clock);
    cmdIf.in_ack = 1'b0;
  endtask

  task automatic doReset(input logic [19:0] k);
    @(negedge Clock);
    #2 Reset = 1'b0;
    keys = k;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b1;
  endtask

  task automatic checkLiteral(input string name, input logic [IC_N-1:0] expCmd, input bit expOvf);
    checkOutput({name, "_dut_cmd"}, cmdIf.in_cmd, expCmd);
    checkOutput({name, "_model_cmd"}, modelHead(), expCmd);
    checkOutput({name, "_dut_ovf"}, cmdIf.ovf, expOvf);
    checkOutput({name, "_model_ovf"}, mOvf, expOvf);
  endtask

  task automatic randPasses(input int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(negedge Clock);
        cmdIf.in_ack = ($urandom_range(0, 5) == 0);
      end while (edgeCnt % PASS != 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [19:0] k;
    Reset        = 1'b0;
    cmdIf.in_ack = 1'b0;
    keys         = '0;
    repeat (3) @(negedge Clock);
    checkLiteral("reset", IC_NONE, 1'b0);
    checkOutput("reset_kp_row", kp_row, 5'b11110);
    #2 Reset = 1'b1;

    $display("[TB] digit 5 press, hold, release");
    applyStimulus(20'h1 << 5, 5);
    checkLiteral("digit5", IC_DIGIT0 + 5'd5, 1'b0);
    applyStimulus(20'h1 << 5, 1);
    applyStimulus('0, 4);
    checkLiteral("digit5_once", IC_DIGIT0 + 5'd5, 1'b0);
    ackOnce();
    checkLiteral("digit5_acked", IC_NONE, 1'b0);

    $display("[TB] bouncing CLBK");
    applyStimulus(20'h1 << 17, 1);
    applyStimulus('0, 1);
    applyStimulus(20'h1 << 17, 1);
    checkLiteral("bounce_quiet", IC_NONE, 1'b0);
    applyStimulus(20'h1 << 17, 4);
    checkLiteral("clbk", IC_CLBK, 1'b0);
    applyStimulus('0, 4);
    checkLiteral("clbk_once", IC_CLBK, 1'b0);
    ackOnce();

    $display("[TB] two keys then one");
    applyStimulus((20'h1 << 10) | (20'h1 << 16), 5);
    checkLiteral("multi_none", IC_NONE, 1'b0);
    applyStimulus(20'h1 << 10, 5);
    checkLiteral("plus", IC_PLUS, 1'b0);
    applyStimulus('0, 4);
    ackOnce();
    checkLiteral("plus_acked", IC_NONE, 1'b0);

    $display("[TB] overflow without acks");
    applyStimulus(20'h1 << 1, 4);
    applyStimulus('0, 4);
    applyStimulus(20'h1 << 2, 4);
    applyStimulus('0, 4);
    applyStimulus(20'h1 << 3, 5);
    checkLiteral("ovf_head1", IC_DIGIT0 + 5'd1, 1'b1);
    applyStimulus('0, 4);
    ackOnce();
    checkLiteral("ovf_head2", IC_DIGIT0 + 5'd2, 1'b1);
    ackOnce();
    checkLiteral("ovf_empty", IC_NONE, 1'b1);

    $display("[TB] ack on the enqueue cycle of a full queue");
    doReset('0);
    applyStimulus(20'h1 << 1, 4);
    applyStimulus('0, 4);
    applyStimulus(20'h1 << 2, 4);
    applyStimulus('0, 4);
    applyStimulus(20'h1 << 3, 4);
    ackOnce();
    checkLiteral("sim_head2", IC_DIGIT0 + 5'd2, 1'b0);
    applyStimulus('0, 4);
    ackOnce();
    checkLiteral("sim_head3", IC_DIGIT0 + 5'd3, 1'b0);
    ackOnce();
    checkLiteral("sim_empty", IC_NONE, 1'b0);

    $display("[TB] reset during debounce with one entry queued");
    applyStimulus(20'h1 << 1, 4);
    applyStimulus('0, 4);
    applyStimulus(20'h1 << 0, 2);
    repeat (7) @(negedge Clock);
    doReset('0);
    checkLiteral("rst_cleared", IC_NONE, 1'b0);
    checkOutput("rst_kp_row", kp_row, 5'b11110);
    applyStimulus('0, 6);
    checkLiteral("rst_quiet", IC_NONE, 1'b0);
    applyStimulus(20'h1 << 0, 5);
    checkLiteral("digit0", IC_DIGIT0, 1'b0);
    applyStimulus('0, 4);
    ackOnce();

    $display("[TB] randomized key patterns and acks");
    for (int it = 0; it < 40; it++) begin
      k = '0;
      case ($urandom_range(0, 4))
        0: k = '0;
        1, 2: k[$urandom_range(0, 19)] = 1'b1;
        3: begin
          k[$urandom_range(0, 19)] = 1'b1;
          k[$urandom_range(0, 19)] = 1'b1;
        end
        default: k = keys;
      endcase
      if (edgeCnt % PASS != 0) waitPasses(1);
      keys = k;
      randPasses($urandom_range(1, 6));
    end
    cmdIf.in_ack = 1'b0;
    keys = '0;
    waitPasses(2);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/keypad_input.md
KEYPAD_INPUT -- requirements
Module: keypad_input

Interface
REQ-001 Parameter SCAN_DIV, default 16: clocks each row stays driven before the scanner advances.
REQ-002 Parameter DEB_N, default 4: consecutive identical full-matrix samples required to accept a press or a release.
REQ-003 Clock  input  1  system clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low.
REQ-005 kp_row  output  5  row drive, active-low, one-cold while scanning.
REQ-006 kp_col  input  4  column sense, active-low, asynchronous to Clock.
REQ-007 in_cmd  output  IC_N  current command to the controller; IC_NONE when the queue is empty.
REQ-008 in_ack  input  1  one-cycle pulse from the controller consuming in_cmd.
REQ-009 ovf  output  1  sticky flag: a key was dropped because the queue was full.

Function
REQ-010 kp_col SHALL pass a 2-flop synchronizer before any use.
REQ-011 Scanner SHALL drive row r low for SCAN_DIV clocks, sample synced kp_col on the last clock, advance r = 0..4 with wrap 4->0.
REQ-012 One full pass (5 rows) SHALL yield one 20-bit snapshot; key index = row*4 + col.
REQ-013 Key map: idx 0-9 = IC digits 0-9; 10 +; 11 -; 12 *; 13 /; 14 (; 15 ); 16 OK; 17 IC_CLBK; 18 IC_CLCL; 19 unused, ignored.
REQ-014 FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
REQ-015 IDLE: snapshot with exactly one key pressed -> DEBOUNCE, latch index, count = 1; zero or multiple keys -> stay.
REQ-016 DEBOUNCE: identical snapshot -> count+1; count reaches DEB_N -> enqueue code, go HELD; any differing snapshot -> IDLE.
REQ-017 HELD: any key pressed -> stay (no auto-repeat); all-released snapshot -> RELEASE, count = 1.
REQ-018 RELEASE: all-released count reaches DEB_N -> IDLE; any press -> HELD.
REQ-019 Queue SHALL be a 2-entry FIFO of IC_N-bit codes; in_cmd = head entry, else IC_NONE.
REQ-020 in_ack with non-empty queue SHALL pop on that edge; in_cmd shows the next entry (or IC_NONE) the following cycle.
REQ-021 in_ack with empty queue SHALL be ignored.
REQ-022 Simultaneous enqueue and in_ack: pop and push both take effect; occupancy unchanged; no overflow, even when full.
REQ-023 Enqueue into a full queue without same-cycle in_ack SHALL drop the new code and set ovf.
REQ-024 ovf SHALL clear only on Reset.
REQ-025 Press-to-in_cmd latency: at most (DEB_N+1) scan passes + 3 clocks after kp_col settles.
REQ-026 in_cmd and ovf SHALL be registered outputs.

Reset
REQ-027 On Reset low: kp_row = 5'b11110, row index 0, divider 0, FSM IDLE, count 0, queue empty, in_cmd = IC_NONE, ovf = 0, synchronizers cleared to all-ones.
REQ-028 Reset asserted mid-debounce or with queue entries SHALL discard all pending keys; no code emitted after release of Reset until a fresh full debounce.

Structure
REQ-029 IC_* command codes and IC_N come from the shared input-interface package; key-map table and FSM state encodings go in a keypad-local constants include.
REQ-030 FIFO SHALL be a sub-module cmd_fifo2 (2-deep, push/pop/full/empty, simultaneous push+pop); scanner, debounce FSM and key map stay in keypad_input.

Verification
REQ-031 Press idx 5 (row 1, col 1), hold 6 passes, release -> in_cmd = digit 5 within REQ-025 bound; exactly one code; in_ack -> IC_NONE next cycle.
REQ-032 Idx 17 bouncing (toggles each pass for 3 passes), then stable 4 passes -> single IC_CLBK, none during bounce.
REQ-033 Idx 10 and 16 pressed together -> no code; release 16 keeping 10 -> single + code.
REQ-034 No in_ack; press 1, 2, 3 in turn -> in_cmd = 1; ovf = 1 after third; acks yield 2 then IC_NONE.
REQ-035 Queue full, in_ack on the exact enqueue cycle of a third key -> ovf stays 0; subsequent codes 2, 3 in order.
REQ-036 Reset pulse during DEBOUNCE of idx 0 with one entry queued -> in_cmd = IC_NONE, kp_row = 5'b11110, no code until key released and re-pressed.
